// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: register identifiers and control inputs
// from the pipeline, forwarding/stall/flush decisions back to it.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             mdu_startE, mdu_done;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        output RdM, RdW, RegWriteM, RegWriteW, mdu_startE, mdu_done,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, mdu_err, stall_count
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        input  RdM, RdW, RegWriteM, RegWriteW, mdu_startE, mdu_done,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, mdu_err, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage RISC-V pipeline: forwarding, load-use stall, branch flush.
// Define HAZARD_CTRL_MDU_EN to add the multi-cycle mul/div hold state with timeout.
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);

    logic             lw_stall;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall_f, stall_d, stall_e;
    logic             flush_d, flush_e, flush_m;
    logic             mdu_err_q;
    logic [CNT_W-1:0] stall_cnt;

    // Memory stage wins over Writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef HAZARD_CTRL_MDU_EN
    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] busy_cnt;
    logic       mdu_err_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            busy_cnt  <= 8'd0;
            mdu_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            mdu_err_q <= mdu_err_nxt;
            // Held at zero in RUN so the first busy cycle sees 0.
            busy_cnt  <= (state == RUN) ? 8'd0 : busy_cnt + 8'd1;
        end
    end
`else
    logic unused_mdu;
    assign unused_mdu = ^{hz.mdu_startE, hz.mdu_done, TO_LAST};
    assign mdu_err_q  = 1'b0;
`endif

    always_comb begin
        lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        fwd_a   = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        fwd_b   = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        stall_f = lw_stall;
        stall_d = lw_stall;
        stall_e = 1'b0;
        flush_d = hz.PCSrcE;
        flush_e = lw_stall | hz.PCSrcE;
        flush_m = 1'b0;
`ifdef HAZARD_CTRL_MDU_EN
        state_nxt   = state;
        mdu_err_nxt = 1'b0;
        case (state)
            RUN: begin
                // A taken branch squashes the mul/div in Execute.
                if (hz.mdu_startE && !hz.PCSrcE)
                    state_nxt = MDU_BUSY;
            end
            MDU_BUSY: begin
                if (hz.mdu_done) begin
                    state_nxt = RUN;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                    flush_m = 1'b1;
                    if (busy_cnt == TO_LAST) begin
                        state_nxt   = RUN;
                        mdu_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
`endif
        if (!reset) begin
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall_f)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign hz.ForwardAE   = fwd_a;
    assign hz.ForwardBE   = fwd_b;
    assign hz.StallF      = stall_f;
    assign hz.StallD      = stall_d;
    assign hz.StallE      = stall_e;
    assign hz.FlushD      = flush_d;
    assign hz.FlushE      = flush_e;
    assign hz.FlushM      = flush_m;
    assign hz.mdu_err     = mdu_err_q;
    assign hz.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; the mul/div section runs when HAZARD_CTRL_MDU_EN is defined.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

`ifdef HAZARD_CTRL_MDU_EN
    logic reset_to;
    hazard_ctrl_if #(.CNT_W(CNT_W)) hz_to ();
    assign {hz_to.Rs1D, hz_to.Rs2D, hz_to.Rs1E, hz_to.Rs2E, hz_to.RdE, hz_to.RdM, hz_to.RdW} =
           {hz.Rs1D, hz.Rs2D, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW};
    assign {hz_to.ResultSrcE, hz_to.PCSrcE, hz_to.RegWriteM, hz_to.RegWriteW} =
           {hz.ResultSrcE, hz.PCSrcE, hz.RegWriteM, hz.RegWriteW};
    assign {hz_to.mdu_startE, hz_to.mdu_done} = {hz.mdu_startE, hz.mdu_done};
    hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(CNT_W)) u_dut_to (
        .clk   (clk),
        .reset (reset_to),
        .hz    (hz_to)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
        hz.RdM = 5'd0; hz.RdW = 5'd0; hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.mdu_startE = 1'b0; hz.mdu_done = 1'b0;
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
`ifdef HAZARD_CTRL_MDU_EN
        reset_to = 1'b0;
`endif
        clear_in();
        // Hazard-provoking inputs while in reset: outputs must still be forced.
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.mdu_startE = 1'b1;
        cyc(2);
        check("rst_StallF", hz.StallF, 1'b0);
        check("rst_StallD", hz.StallD, 1'b0);
        check("rst_StallE", hz.StallE, 1'b0);
        check("rst_FlushD", hz.FlushD, 1'b1);
        check("rst_FlushE", hz.FlushE, 1'b1);
        check("rst_FlushM", hz.FlushM, 1'b1);
        check("rst_FwdA", hz.ForwardAE, 2'b00);
        check("rst_FwdB", hz.ForwardBE, 2'b00);
        check("rst_count", hz.stall_count, 0);
        check("rst_err", hz.mdu_err, 1'b0);

        reset = 1'b1;
        clear_in();
        #1;
        check("idle_FlushD", hz.FlushD, 1'b0);
        check("idle_FlushE", hz.FlushE, 1'b0);
        check("idle_FlushM", hz.FlushM, 1'b0);

        // Forwarding
        cyc(1);
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        #1 check("fwdA_mem_prio", hz.ForwardAE, 2'b10);
        hz.RdM = 5'd0;
        #1 check("fwdA_wb", hz.ForwardAE, 2'b01);
        hz.Rs2E = 5'd9; hz.RdW = 5'd9; hz.RdM = 5'd9; hz.RegWriteM = 1'b0;
        #1 check("fwdB_wb_mwe0", hz.ForwardBE, 2'b01);
        check("fwdA_nomatch", hz.ForwardAE, 2'b00);
        hz.RegWriteM = 1'b1;
        #1 check("fwdB_mem", hz.ForwardBE, 2'b10);
        cyc(1);
        hz.Rs2E = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        #1 check("fwdB_x0", hz.ForwardBE, 2'b00);

        // Load-use
        cyc(1);
        clear_in();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        check("lw_StallF", hz.StallF, 1'b1);
        check("lw_StallD", hz.StallD, 1'b1);
        check("lw_FlushE", hz.FlushE, 1'b1);
        check("lw_FlushD", hz.FlushD, 1'b0);
        hz.RdE = 5'd0;
        #1;
        check("lw_x0_StallF", hz.StallF, 1'b0);
        check("lw_x0_StallD", hz.StallD, 1'b0);
        check("lw_x0_FlushE", hz.FlushE, 1'b0);
        check("lw_x0_FlushD", hz.FlushD, 1'b0);
        hz.RdE = 5'd7; hz.Rs2D = 5'd0; hz.Rs1D = 5'd7;
        #1 check("lw_rs1_StallF", hz.StallF, 1'b1);
        hz.ResultSrcE = 2'b10;
        #1 check("nonload_StallF", hz.StallF, 1'b0);

        // Branch together with load-use
        cyc(1);
        clear_in();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.PCSrcE = 1'b1;
        #1;
        check("br_lw_FlushD", hz.FlushD, 1'b1);
        check("br_lw_FlushE", hz.FlushE, 1'b1);
        check("br_lw_StallF", hz.StallF, 1'b1);
        check("br_lw_StallE", hz.StallE, 1'b0);
        check("br_lw_FlushM", hz.FlushM, 1'b0);
        cyc(1);
        check("count_one", hz.stall_count, 1);
        clear_in();
        hz.PCSrcE = 1'b1;
        #1;
        check("br_FlushD", hz.FlushD, 1'b1);
        check("br_FlushE", hz.FlushE, 1'b1);
        check("br_StallF", hz.StallF, 1'b0);
        cyc(1);
        check("count_hold", hz.stall_count, 1);

        // Mid-run reset clears the stall counter
        clear_in();
        reset = 1'b0;
        cyc(1);
        check("rst2_count", hz.stall_count, 0);
        reset = 1'b1;

`ifdef HAZARD_CTRL_MDU_EN
        // Start squashed by a simultaneous branch
        hz.mdu_startE = 1'b1; hz.PCSrcE = 1'b1;
        cyc(1);
        clear_in();
        #1 check("start_squashed_StallE", hz.StallE, 1'b0);

        // Mul/div completing on the 10th busy cycle
        cyc(1);
        hz.mdu_startE = 1'b1;
        #1 check("start_cycle_StallE", hz.StallE, 1'b0);
        cyc(1);
        hz.mdu_startE = 1'b0;
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        #1;
        check("busy_FlushM", hz.FlushM, 1'b1);
        check("busy_FlushD", hz.FlushD, 1'b0);
        check("busy_fwdA", hz.ForwardAE, 2'b10);
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("busy_StallE_%0d", i), hz.StallE, 1'b1);
            cyc(1);
        end
        hz.mdu_done = 1'b1;
        #1;
        check("done_StallE", hz.StallE, 1'b0);
        check("done_FlushM", hz.FlushM, 1'b0);
        cyc(1);
        hz.mdu_done = 1'b0;
        #1;
        check("after_done_StallE", hz.StallE, 1'b0);
        check("mdu_count", hz.stall_count, 9);
        check("done_no_err", hz.mdu_err, 1'b0);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        clear_in();
`else
        // Without the MDU option the start/done inputs have no effect
        hz.mdu_startE = 1'b1;
        cyc(1);
        hz.mdu_startE = 1'b0;
        #1;
        check("nomdu_StallE", hz.StallE, 1'b0);
        check("nomdu_FlushM", hz.FlushM, 1'b0);
        check("nomdu_StallF", hz.StallF, 1'b0);
        cyc(3);
        check("nomdu_err", hz.mdu_err, 1'b0);
        check("nomdu_count", hz.stall_count, 0);
`endif

        // Saturating stall counter
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
        cyc(5);
        check("sat_count5", hz.stall_count, 5);
        cyc(10);
        check("sat_count15", hz.stall_count, 15);
        cyc(3);
        check("sat_hold", hz.stall_count, 15);
        clear_in();
        cyc(1);
        check("sat_idle", hz.stall_count, 15);

`ifdef HAZARD_CTRL_MDU_EN
        // Timeout instance (MDU_TIMEOUT=4)
        reset_to = 1'b1;
        cyc(1);
        hz.mdu_startE = 1'b1;
        cyc(1);
        hz.mdu_startE = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 check($sformatf("to_busy_StallE_%0d", i), hz_to.StallE, 1'b1);
            cyc(1);
        end
        check("to_exit_StallE", hz_to.StallE, 1'b0);
        check("to_err_pulse", hz_to.mdu_err, 1'b1);
        cyc(1);
        check("to_err_one_cycle", hz_to.mdu_err, 1'b0);
        hz.mdu_startE = 1'b1;
        cyc(1);
        hz.mdu_startE = 1'b0;
        cyc(1);
        check("to_busy_again", hz_to.StallE, 1'b1);
        reset_to = 1'b0;
        cyc(1);
        check("to_rst_StallE", hz_to.StallE, 1'b0);
        check("to_rst_err", hz_to.mdu_err, 1'b0);
        reset_to = 1'b1;
        cyc(4);
        check("to_rst_no_late_err", hz_to.mdu_err, 1'b0);
        check("to_rst_run", hz_to.StallE, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
